// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 12-bit serial ADC with leading zeros.
// The reading is a saturating register stepped by inc/dec strobes.
module adc_spi_responder #(
    parameter int DATA_BITS   = 12,
    parameter int LEAD_ZEROS  = 4,
    parameter int STEP        = 16,
    parameter int RESET_VALUE = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs_n,
    input  logic                 sclk,
    output logic                 sdata,
    output logic                 sdata_oe,
    input  logic                 inc,
    input  logic                 dec,
    output logic [DATA_BITS-1:0] value,
    output logic                 frame_done
);

    localparam int FRAME = LEAD_ZEROS + DATA_BITS;
    localparam int CW    = $clog2(FRAME);

    localparam logic [DATA_BITS:0]   MAX_W  = {1'b0, {DATA_BITS{1'b1}}};
    localparam logic [DATA_BITS:0]   STEP_W = (DATA_BITS+1)'(STEP);
    localparam logic [DATA_BITS-1:0] STEP_D = DATA_BITS'(STEP);
    localparam logic [CW-1:0]        LAST   = CW'(FRAME - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           cs_sync_q, cs_sync_d;
    logic [2:0]           sck_sync_q, sck_sync_d;
    logic [DATA_BITS-1:0] value_q, value_d;
    logic [FRAME-1:0]     shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 oe_q, oe_d;
    logic                 done_q, done_d;

    logic                 cs_fall, cs_rise, sck_fall;
    logic [DATA_BITS:0]   up_sum;

    // bit 0 first stage, bit 1 synchronized, bit 2 history
    assign cs_sync_d  = {cs_sync_q[1:0], cs_n};
    assign sck_sync_d = {sck_sync_q[1:0], sclk};
    assign cs_fall    = cs_sync_q[2] & ~cs_sync_q[1];
    assign cs_rise    = ~cs_sync_q[2] & cs_sync_q[1];
    assign sck_fall   = sck_sync_q[2] & ~sck_sync_q[1];

    assign up_sum = {1'b0, value_q} + STEP_W;

    always_comb begin
        value_d = value_q;
        if (inc && !dec) begin
            value_d = (up_sum > MAX_W) ? MAX_W[DATA_BITS-1:0]
                                       : up_sum[DATA_BITS-1:0];
        end else if (dec && !inc) begin
            value_d = (value_q < STEP_D) ? '0 : value_q - STEP_D;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        if (cs_rise) begin
            // a deselect always wins, even over a coincident sclk fall
            state_d = IDLE;
            shift_d = '0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    oe_d = 1'b0;
                    if (cs_fall) begin
                        shift_d = {{LEAD_ZEROS{1'b0}}, value_q};
                        cnt_d   = '0;
                        oe_d    = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_fall) begin
                        if (cnt_q == LAST) begin
                            shift_d = '0;
                            oe_d    = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            shift_d = {shift_q[FRAME-2:0], 1'b0};
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cs_sync_q  <= '1;
            sck_sync_q <= '1;
            value_q    <= DATA_BITS'(RESET_VALUE);
            shift_q    <= '0;
            cnt_q      <= '0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_sync_q  <= cs_sync_d;
            sck_sync_q <= sck_sync_d;
            value_q    <= value_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
        end
    end

    assign sdata      = shift_q[FRAME-1] & oe_q;
    assign sdata_oe   = oe_q;
    assign value      = value_q;
    assign frame_done = done_q;

endmodule
